tile_write_sched: RTL and testbench
===================================

# tile_write_sched

Write-side sequencer for the tile-map and tile-pixel memories of the HDMI tile renderer. It accepts one command at a time over a valid/ready handshake and expands it into single-cycle write strobes on the tile map (`tm_*`) and tile pixel store (`t_*`) write ports. Supported commands are single writes, rectangular map fills and whole-tile fills. Write strobes are issued only while the display read phase (`r_active`) is low, so writes never collide with scan-out reads.

## Interface

**Parameters**
- `MAP_W`, default 80: tile-map width in tiles.
- `MAP_H`, default 60: tile-map height in tiles.

**Ports**
- `clk` in 1: 125 MHz system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block idle; command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: command opcode.
  - 0 = MAP_WR
  - 1 = PIX_WR
  - 2 = MAP_FILL
  - 3 = TILE_FILL
- `cmd_x` in 7: map column (MAP ops).
- `cmd_y` in 6: map row (MAP ops).
- `cmd_w` in 7: fill width in tiles (MAP_FILL).
- `cmd_h` in 6: fill height in tiles (MAP_FILL).
- `cmd_adr` in 6: tile index (PIX_WR, TILE_FILL).
- `cmd_px` in 3: pixel column within the tile (PIX_WR).
- `cmd_py` in 3: pixel row within the tile (PIX_WR).
- `cmd_data` in 24: payload.
  - MAP ops use `[5:0]` as the tile index.
  - PIX ops use `[23:0]` as colour {b,g,r}.
- `r_active` in 1: display read phase; while high, no write strobe is issued.
- `tm_write_x` out 7, `tm_write_y` out 6, `tm_v` out 6, `tm_w` out 1: tile-map write port.
- `t_write_x` out 3, `t_write_y` out 3, `t_write_adr` out 6, `t_v` out 24, `t_w` out 1: tile pixel write port.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation

**Reset.** All outputs are registered. On reset, every output is 0, including `cmd_ready`, and the FSM goes to IDLE. From the first cycle after `rst_n` rises, `cmd_ready` is 1.

**FSM states and transitions**
- IDLE:
  - `cmd_ready` is 1.
  - On handshake, all `cmd_*` fields are latched; `cmd_ready` drops to 0 and `busy` rises to 1 on the next edge.
  - Next state:
    - MAP_WR or PIX_WR → SINGLE.
    - MAP_FILL → MFILL.
    - TILE_FILL → TFILL.
- SINGLE: issues one write, then goes to DONE.
- MFILL: walks the fill rectangle in raster order.
  - Column offset `i` runs 0..w-1 (inner loop); row offset `j` runs 0..h-1 (outer loop).
  - Target is (x+i, y+j) with value `tm_v = data[5:0]`.
  - After the last location, goes to DONE.
- TFILL: writes `data` to all 64 pixels of tile `adr`, `py` outer and `px` inner (0..7 each), then goes to DONE.
- DONE:
  - `done` is 1 and `busy` is 0 for this one cycle, and `cmd_ready` returns to 1 in the same cycle.
  - Next state is IDLE.

**Write slots**
- A write slot is any cycle in SINGLE, MFILL or TFILL where `r_active` was low at the previous edge.
- In a slot, the relevant strobe (`tm_w` or `t_w`) is 1 for exactly one cycle with its address and data valid, and the iteration counter advances.
- Outside a slot, strobes are 0, counters hold, and address/data outputs hold their last values.
- `tm_w` and `t_w` are never high in the same cycle.

**Arithmetic**
- x+i is computed 8 bits wide; y+j is computed 7 bits wide.
- Coordinates that fall outside the map are handled per Configuration.

**Boundary conditions**
- MAP_FILL with `cmd_w == 0` or `cmd_h == 0`: no writes; goes straight to DONE.
- A MAP_FILL covering the full 80×60 map makes 4800 writes; the counters must not overflow.
- `cmd_valid` asserted while busy is ignored and does not disturb the command in progress.
- `rst_n` low mid-command aborts the command: strobes are 0 on the next edge and no `done` pulse is produced.

## Timing

- Handshake at edge N: earliest strobe at edge N+1, provided `r_active` was low at edge N.
- With `r_active` held low:
  - SINGLE: strobe at N+1, `done` at N+2, next accept possible at N+2.
  - MFILL: w·h slot cycles plus 1 DONE cycle.
  - TFILL: 64 slot cycles plus 1 DONE cycle.
- Each cycle with `r_active` high adds exactly one cycle of latency.
- Write outputs connect directly to the memories' synchronous write ports; there is no further pipelining.

## Configuration

- `TILE_SCHED_CLIP_EN` defined:
  - MFILL locations with x+i ≥ MAP_W or y+j ≥ MAP_H are clipped.
  - A clipped location still consumes its slot, but `tm_w` stays 0 for it.
- `TILE_SCHED_CLIP_EN` undefined:
  - Coordinates wrap: x = (x+i) mod MAP_W, y = (y+j) mod MAP_H.
  - Every slot writes.

## Test plan

- **Reset and single map write.** Release reset, then MAP_WR x=5, y=7, data=0x2A, with `r_active`=0. Required: `tm_w` high for 1 cycle with (5, 7, 0x2A) at N+1; `done` at N+2; `cmd_ready`=1 at N+2.
- **Single pixel write under stall.** PIX_WR adr=3, px=2, py=6, data=0xFF8000, with `r_active` high for 10 cycles after accept. Required: no `t_w` during the stall; one `t_w` with (2, 6, 3, 0xFF8000) on the first slot.
- **Tile fill.** TILE_FILL adr=63, data=0x123456. Required: exactly 64 `t_w` pulses covering (px, py) = (0,0)…(7,7) in raster order; `done` once; 65 cycles total with `r_active` low.
- **Edge fill, clip on.** MAP_FILL x=78, y=58, w=4, h=4 with `TILE_SCHED_CLIP_EN` defined. Required: 4 writes at (78..79, 58..59); 16 slot cycles consumed.
- **Edge fill, wrap on.** Same command without `TILE_SCHED_CLIP_EN`. Required: 16 writes, including (0,0) and (1,1).
- **Zero size, ignored valid, reset abort.**
  - MAP_FILL w=0: `done` at N+1 with no writes.
  - `cmd_valid` pulsed during a fill: ignored.
  - `rst_n` low mid-TFILL: strobes 0 on the next edge, no `done`, `cmd_ready`=1 one cycle after reset is released.

Source files
------------

// File: rtl/tile_write_sched.sv
// rtl/tile_write_sched.sv - write sequencer for tile map and tile pixel memories
// Optional TILE_SCHED_CLIP_EN: clip out-of-map fill locations instead of wrapping them.
module tile_write_sched #(
    parameter int MAP_W = 80,
    parameter int MAP_H = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_x,
    input  logic [5:0]  cmd_y,
    input  logic [6:0]  cmd_w,
    input  logic [5:0]  cmd_h,
    input  logic [5:0]  cmd_adr,
    input  logic [2:0]  cmd_px,
    input  logic [2:0]  cmd_py,
    input  logic [23:0] cmd_data,
    input  logic        r_active,
    output logic [6:0]  tm_write_x,
    output logic [5:0]  tm_write_y,
    output logic [5:0]  tm_v,
    output logic        tm_w,
    output logic [2:0]  t_write_x,
    output logic [2:0]  t_write_y,
    output logic [5:0]  t_write_adr,
    output logic [23:0] t_v,
    output logic        t_w,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] OP_MAP_WR = 2'd0;
    localparam logic [1:0] OP_MAP_FILL = 2'd2;
    localparam logic [1:0] OP_TILE_FILL = 2'd3;
    localparam logic [7:0] MAP_W8 = 8'(MAP_W);
    localparam logic [6:0] MAP_H7 = 7'(MAP_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SINGLE,
        S_MFILL,
        S_TFILL,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [6:0]  x_q, x_d, w_q, w_d, i_q, i_d;
    logic [5:0]  y_q, y_d, h_q, h_d, j_q, j_d, adr_q, adr_d;
    logic [2:0]  px_q, px_d, py_q, py_d;
    logic [23:0] data_q, data_d;
    logic        ra_q;
    logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [6:0]  tmx_q, tmx_d;
    logic [5:0]  tmy_q, tmy_d, tmv_q, tmv_d, tadr_q, tadr_d;
    logic        tmw_q, tmw_d, tw_q, tw_d;
    logic [2:0]  tx_q, tx_d, ty_q, ty_d;
    logic [23:0] tv_q, tv_d;

    logic        slot;
    logic [7:0]  sx;
    logic [6:0]  sy;
    logic        last_col, last_row;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            adr_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            data_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ra_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmx_q   <= '0;
            tmy_q   <= '0;
            tmv_q   <= '0;
            tmw_q   <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            tadr_q  <= '0;
            tv_q    <= '0;
            tw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            adr_q   <= adr_d;
            px_q    <= px_d;
            py_q    <= py_d;
            data_q  <= data_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ra_q    <= r_active;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmx_q   <= tmx_d;
            tmy_q   <= tmy_d;
            tmv_q   <= tmv_d;
            tmw_q   <= tmw_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tadr_q  <= tadr_d;
            tv_q    <= tv_d;
            tw_q    <= tw_d;
        end
    end

    // ra_q holds r_active from the previous edge; a slot exists only when it was low
    assign slot     = !ra_q;
    assign sx       = {1'b0, x_q} + {1'b0, i_q};
    assign sy       = {1'b0, y_q} + {1'b0, j_q};
    assign last_col = (({1'b0, i_q} + 8'd1) == {1'b0, w_q});
    assign last_row = (({1'b0, j_q} + 7'd1) == {1'b0, h_q});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        adr_d   = adr_q;
        px_d    = px_q;
        py_d    = py_q;
        data_d  = data_q;
        i_d     = i_q;
        j_d     = j_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmx_d   = tmx_q;
        tmy_d   = tmy_q;
        tmv_d   = tmv_q;
        tmw_d   = 1'b0;
        tx_d    = tx_q;
        ty_d    = ty_q;
        tadr_d  = tadr_q;
        tv_d    = tv_q;
        tw_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    adr_d   = cmd_adr;
                    px_d    = cmd_px;
                    py_d    = cmd_py;
                    data_d  = cmd_data;
                    i_d     = '0;
                    j_d     = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (cmd_op == OP_MAP_FILL) begin
                        state_d = (cmd_w == '0 || cmd_h == '0) ? S_DONE : S_MFILL;
                    end else if (cmd_op == OP_TILE_FILL) begin
                        state_d = S_TFILL;
                    end else begin
                        state_d = S_SINGLE;
                    end
                end
            end
            S_SINGLE: begin
                if (slot) begin
                    if (op_q == OP_MAP_WR) begin
                        tmw_d = 1'b1;
                        tmx_d = x_q;
                        tmy_d = y_q;
                        tmv_d = data_q[5:0];
                    end else begin
                        tw_d   = 1'b1;
                        tx_d   = px_q;
                        ty_d   = py_q;
                        tadr_d = adr_q;
                        tv_d   = data_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_MFILL: begin
                if (slot) begin
`ifdef TILE_SCHED_CLIP_EN
                    if (sx < MAP_W8 && sy < MAP_H7) begin
                        tmw_d = 1'b1;
                        tmx_d = sx[6:0];
                        tmy_d = sy[5:0];
                        tmv_d = data_q[5:0];
                    end
`else
                    tmw_d = 1'b1;
                    tmx_d = 7'(sx % MAP_W8);
                    tmy_d = 6'(sy % MAP_H7);
                    tmv_d = data_q[5:0];
`endif
                    if (last_col) begin
                        i_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            j_d = j_q + 6'd1;
                        end
                    end else begin
                        i_d = i_q + 7'd1;
                    end
                end
            end
            S_TFILL: begin
                if (slot) begin
                    tw_d   = 1'b1;
                    tx_d   = i_q[2:0];
                    ty_d   = j_q[2:0];
                    tadr_d = adr_q;
                    tv_d   = data_q;
                    if (i_q[2:0] == 3'd7) begin
                        i_d = '0;
                        if (j_q[2:0] == 3'd7) begin
                            state_d = S_DONE;
                        end else begin
                            j_d = j_q + 6'd1;
                        end
                    end else begin
                        i_d = i_q + 7'd1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tm_write_x  = tmx_q;
    assign tm_write_y  = tmy_q;
    assign tm_v        = tmv_q;
    assign tm_w        = tmw_q;
    assign t_write_x   = tx_q;
    assign t_write_y   = ty_q;
    assign t_write_adr = tadr_q;
    assign t_v         = tv_q;
    assign t_w         = tw_q;
endmodule

// File: tb/tb_tile_write_sched.sv
// tb/tb_tile_write_sched.sv - table-driven bench for tile_write_sched
module tb_tile_write_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [6:0]  cmd_w;
    logic [5:0]  cmd_h;
    logic [5:0]  cmd_adr;
    logic [2:0]  cmd_px;
    logic [2:0]  cmd_py;
    logic [23:0] cmd_data;
    logic        r_active;
    logic [6:0]  tm_write_x;
    logic [5:0]  tm_write_y;
    logic [5:0]  tm_v;
    logic        tm_w;
    logic [2:0]  t_write_x;
    logic [2:0]  t_write_y;
    logic [5:0]  t_write_adr;
    logic [23:0] t_v;
    logic        t_w;
    logic        busy;
    logic        done;

    tile_write_sched dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_adr(cmd_adr), .cmd_px(cmd_px), .cmd_py(cmd_py), .cmd_data(cmd_data),
        .r_active(r_active), .tm_write_x(tm_write_x), .tm_write_y(tm_write_y),
        .tm_v(tm_v), .tm_w(tm_w), .t_write_x(t_write_x), .t_write_y(t_write_y),
        .t_write_adr(t_write_adr), .t_v(t_v), .t_w(t_w), .busy(busy), .done(done)
    );

    always #4 clk = ~clk;

    typedef struct {
        int op, x, y, w, h, adr, px, py, data, stall;
        bit poke;
        int exp_nwr, exp_first, exp_done, exp_lx, exp_ly;
    } vec_t;

    typedef struct {
        bit is_t;
        int x, y, adr, v;
    } wr_t;

    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];
    vec_t vt[10];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic build_exp(input vec_t v);
        wr_t e;
        exp_q.delete();
        case (v.op)
            0: begin e = '{1'b0, v.x, v.y, 0, v.data & 63}; exp_q.push_back(e); end
            1: begin e = '{1'b1, v.px, v.py, v.adr, v.data}; exp_q.push_back(e); end
            2: for (int j = 0; j < v.h; j++) begin
                   for (int i = 0; i < v.w; i++) begin
`ifdef TILE_SCHED_CLIP_EN
                       if (v.x + i < 80 && v.y + j < 60) begin
                           e = '{1'b0, v.x + i, v.y + j, 0, v.data & 63};
                           exp_q.push_back(e);
                       end
`else
                       e = '{1'b0, (v.x + i) % 80, (v.y + j) % 60, 0, v.data & 63};
                       exp_q.push_back(e);
`endif
                   end
               end
            default: for (int py = 0; py < 8; py++) begin
                         for (int px = 0; px < 8; px++) begin
                             e = '{1'b1, px, py, v.adr, v.data};
                             exp_q.push_back(e);
                         end
                     end
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", int'(cmd_ready), 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int k = 0, nwr = 0, first_k = 0, done_k = 0, bad_wr = 0;
        int lx = -1, ly = -1, rdy_at_done = 0, busy_at_done = 1;
        wr_t e;
        build_exp(v);
        wait_ready();
        cmd_op    = 2'(v.op);
        cmd_x     = 7'(v.x);
        cmd_y     = 6'(v.y);
        cmd_w     = 7'(v.w);
        cmd_h     = 6'(v.h);
        cmd_adr   = 6'(v.adr);
        cmd_px    = 3'(v.px);
        cmd_py    = 3'(v.py);
        cmd_data  = 24'(v.data);
        cmd_valid = 1'b1;
        r_active  = (v.stall > 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        while (done_k == 0 && k < 6000) begin
            @(negedge clk);
            r_active = (k + 1 < v.stall);
            if (v.poke && k >= 2 && k < 5) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'd0;
                cmd_x     = 7'd100;
                cmd_data  = 24'h00003F;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1 k++;
            if (tm_w && t_w) bad_wr++;
            if (tm_w || t_w) begin
                if (first_k == 0) first_k = k;
                if (nwr < exp_q.size()) begin
                    e = exp_q[nwr];
                    if (e.is_t != t_w) bad_wr++;
                    else if (t_w && (int'(t_write_x) != e.x || int'(t_write_y) != e.y ||
                                     int'(t_write_adr) != e.adr || int'(t_v) != e.v)) bad_wr++;
                    else if (tm_w && (int'(tm_write_x) != e.x || int'(tm_write_y) != e.y ||
                                      int'(tm_v) != e.v)) bad_wr++;
                end else begin
                    bad_wr++;
                end
                lx = t_w ? int'(t_write_x) : int'(tm_write_x);
                ly = t_w ? int'(t_write_y) : int'(tm_write_y);
                nwr++;
            end
            if (done) begin
                done_k       = k;
                rdy_at_done  = int'(cmd_ready);
                busy_at_done = int'(busy);
            end
        end
        cmd_valid = 1'b0;
        r_active  = 1'b0;
        $display("vector %0d:", idx);
        chk("  done_cycle", done_k, v.exp_done);
        chk("  write_count", nwr, v.exp_nwr);
        chk("  model_write_count", nwr, exp_q.size());
        chk("  first_write_cycle", first_k, v.exp_first);
        chk("  write_contents", bad_wr, 0);
        chk("  last_x", lx, v.exp_lx);
        chk("  last_y", ly, v.exp_ly);
        chk("  ready_at_done", rdy_at_done, 1);
        chk("  busy_at_done", busy_at_done, 0);
    endtask

    initial begin
        int n;
        int nt;
        int seen_done;
        //        op  x   y   w   h   adr px py data       stall poke nwr  first done  lx  ly
        vt[0] = '{0,  5,  7,  0,  0,  0,  0, 0, 'h2A,      0,    0,   1,    1,    2,   5,  7};
        vt[1] = '{1,  0,  0,  0,  0,  3,  2, 6, 'hFF8000,  10,   0,   1,   11,   12,   2,  6};
        vt[2] = '{3,  0,  0,  0,  0,  63, 0, 0, 'h123456,  0,    0,   64,   1,   65,   7,  7};
`ifdef TILE_SCHED_CLIP_EN
        vt[3] = '{2,  78, 58, 4,  4,  0,  0, 0, 'h11,      0,    0,   4,    1,   17,  79, 59};
`else
        vt[3] = '{2,  78, 58, 4,  4,  0,  0, 0, 'h11,      0,    0,   16,   1,   17,   1,  1};
`endif
        vt[4] = '{2,  3,  3,  0,  4,  0,  0, 0, 'h05,      0,    0,   0,    0,    1,  -1, -1};
        vt[5] = '{2,  10, 20, 3,  2,  0,  0, 0, 'h15,      3,    0,   6,    4,   10,  12, 21};
        vt[6] = '{2,  0,  0,  80, 60, 0,  0, 0, 'h3F,      0,    0,   4800, 1, 4801,  79, 59};
        vt[7] = '{2,  5,  5,  5,  0,  0,  0, 0, 'h09,      0,    0,   0,    0,    1,  -1, -1};
        vt[8] = '{2,  0,  0,  10, 2,  0,  0, 0, 'h07,      0,    1,   20,   1,   21,   9,  1};
        vt[9] = '{1,  0,  0,  0,  0,  0,  7, 0, 'h00ABCD,  1,    0,   1,    2,    3,   7,  0};

        rst_n = 1'b0; cmd_valid = 1'b0; r_active = 1'b0;
        cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_adr = '0; cmd_px = '0; cmd_py = '0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_busy_done", int'({busy, done}), 0);
        chk("reset_strobes", int'({tm_w, t_w}), 0);
        chk("reset_tm_port", int'({tm_write_x, tm_write_y, tm_v}), 0);
        chk("reset_t_port", int'({t_write_x, t_write_y, t_write_adr}), 0);
        chk("reset_t_v", int'(t_v), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", int'(cmd_ready), 1);

        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

        // abort a tile fill part way through with reset
        wait_ready();
        cmd_op = 2'd3; cmd_adr = 6'd9; cmd_data = 24'h0F0F0F; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        nt = 0;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (t_w) nt++;
            if (done) seen_done++;
        end
        chk("abort_pre_writes", nt, 10);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_strobes", int'({tm_w, t_w}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 0);
        if (done) seen_done++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_after_release", int'(cmd_ready), 1);
        if (done) seen_done++;
        n = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (t_w || tm_w) n++;
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_no_writes_after", n, 0);

        run_vec(10, vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
